// File: rtl/instruction_fetch.sv
// Instruction fetch unit: two-entry prefetch buffer in front of a one-cycle program memory.
// Presents one- and two-word instructions to the decoder with a valid/ready handshake and jump redirect.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_pm_addr,
  input  logic [15:0] i_pm_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_instr,
  output logic [15:0] o_instr_ext,
  output logic        o_two_word,
  output logic [15:0] o_pc,
  input  logic        i_jump_valid,
  input  logic [15:0] i_jump_addr
);

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] word;
  } entry_t;

  entry_t      fifo_q [DEPTH];
  entry_t      fifo_d [DEPTH];
  logic [1:0]  count_q, count_d, pop_n, cnt_pop;
  logic        inflight_q;
  logic [15:0] inflight_addr_q;
  logic [15:0] pc_q;
  logic        head_two, present, fire, issue;

  // JMP/CALL and LDS/STS carry a second operand word.
  function automatic logic is_two_word(input logic [15:0] w);
    return ((w & 16'hFE0C) == 16'h940C) ||
           ((w & 16'hFE0F) == 16'h9000) ||
           ((w & 16'hFE0F) == 16'h9200);
  endfunction

  assign o_pm_addr = pc_q;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    head_two    = is_two_word(fifo_q[0].word);
    present     = !i_rst && ((count_q == 2'd2) || (count_q == 2'd1 && !head_two));
    fire        = present && i_ready;
    pop_n       = fire ? (head_two ? 2'd2 : 2'd1) : 2'd0;
    cnt_pop     = count_q - pop_n;
    issue       = ({1'b0, count_q} + {2'b00, inflight_q} - {1'b0, pop_n}) < 3'd2;
    fifo_d      = fifo_q;
    if (pop_n == 2'd1) fifo_d[0] = fifo_q[1];
    // The returning word lands right behind whatever survives this cycle's pop.
    if (inflight_q) fifo_d[cnt_pop[0]] = '{addr: inflight_addr_q, word: i_pm_data};
    count_d     = cnt_pop + {1'b0, inflight_q};

    o_valid     = present;
    o_instr     = 16'h0000;
    o_instr_ext = 16'h0000;
    o_two_word  = 1'b0;
    o_pc        = 16'h0000;
    if (present) begin
      o_instr    = fifo_q[0].word;
      o_pc       = fifo_q[0].addr;
      o_two_word = head_two;
      if (head_two) o_instr_ext = fifo_q[1].word;
    end
  end

  // NOTE: non-blocking assignments for all state so each register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q            <= RESET_PC;
      count_q         <= 2'd0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= RESET_PC;
    end else if (i_jump_valid) begin
      // Flush and squash: the word already in flight is dropped by clearing inflight_q.
      pc_q       <= i_jump_addr;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_addr_q <= pc_q;
        pc_q            <= pc_q + 16'd1;
      end
    end
  end

  // NOTE: buffer storage is not reset; count_q alone decides which entries are live.
  always_ff @(posedge i_clk) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_jump_valid) begin
      assert (!(inflight_q && cnt_pop == 2'd2));
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: expected instructions are queued by the stimulus
// and a monitor compares each accepted instruction; cycle-specific checks run inline.
module tb_instruction_fetch;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] ext;
    logic        two;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] o_pm_addr;
  logic [15:0] i_pm_data = 16'h0000;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [15:0] o_instr, o_instr_ext, o_pc;
  logic        o_two_word;
  logic        i_jump_valid = 1'b0;
  logic [15:0] i_jump_addr = 16'h0000;

  logic [15:0] mem [65536];
  exp_t        sb [$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;

  instruction_fetch #(.RESET_PC(16'h0000)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .o_pm_addr    (o_pm_addr),
    .i_pm_data    (i_pm_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_instr      (o_instr),
    .o_instr_ext  (o_instr_ext),
    .o_two_word   (o_two_word),
    .o_pc         (o_pc),
    .i_jump_valid (i_jump_valid),
    .i_jump_addr  (i_jump_addr)
  );

  always #5 i_clk = ~i_clk;

  // Program memory with one cycle of read latency.
  always @(posedge i_clk) i_pm_data <= mem[o_pm_addr];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] instr,
                      input logic [15:0] ext, input logic two);
    exp_t e;
    e.pc = pc; e.instr = instr; e.ext = ext; e.two = two;
    sb.push_back(e);
  endtask

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge i_clk) begin
    if (o_valid && i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: accepted pc %h instr %h with nothing expected", o_pc, o_instr);
      end else begin
        mon_e = sb.pop_front();
        check("sb_pc",    o_pc,        mon_e.pc);
        check("sb_instr", o_instr,     mon_e.instr);
        check("sb_ext",   o_instr_ext, mon_e.ext);
        check("sb_two",   {15'b0, o_two_word}, {15'b0, mon_e.two});
      end
    end
  end

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 16'h0000;
  endtask

  task automatic load_stream();
    clear_mem();
    mem[0] = 16'hC003; mem[1] = 16'hFE00; mem[2] = 16'hCFFF;
    mem[3] = 16'hCFFF; mem[4] = 16'h9409;
  endtask

  // Leaves the bench at the start of cycle 0 (first cycle with reset low).
  task automatic do_reset();
    next_cycle();
    i_rst = 1'b1; i_ready = 1'b0; i_jump_valid = 1'b0;
    repeat (2) next_cycle();
    @(negedge i_clk);
    check("rst_valid",   {15'b0, o_valid}, 16'h0000);
    check("rst_instr",   o_instr,   16'h0000);
    check("rst_pc",      o_pc,      16'h0000);
    check("rst_pm_addr", o_pm_addr, 16'h0000);
    next_cycle();
    i_rst = 1'b0;
  endtask

  task automatic check_drained(input string name);
    check(name, 16'(sb.size()), 16'h0000);
    sb.delete();
  endtask

  initial begin
    // Stream with i_ready held high: one instruction per cycle from cycle 2.
    load_stream();
    push(16'h0000, 16'hC003, 16'h0000, 1'b0);
    push(16'h0001, 16'hFE00, 16'h0000, 1'b0);
    push(16'h0002, 16'hCFFF, 16'h0000, 1'b0);
    push(16'h0003, 16'hCFFF, 16'h0000, 1'b0);
    push(16'h0004, 16'h9409, 16'h0000, 1'b0);
    do_reset();
    for (int c = 0; c < 8; c++) begin
      i_ready = (c <= 6);
      @(negedge i_clk);
      if (c == 0) check("stream_pm_addr0", o_pm_addr, 16'h0000);
      if (c <= 6) check("stream_valid", {15'b0, o_valid}, (c >= 2) ? 16'h0001 : 16'h0000);
      next_cycle();
    end
    check_drained("stream_drained");

    // Stall in cycles 3..6: FE00 held, fetch address parked at 3.
    push(16'h0000, 16'hC003, 16'h0000, 1'b0);
    push(16'h0001, 16'hFE00, 16'h0000, 1'b0);
    push(16'h0002, 16'hCFFF, 16'h0000, 1'b0);
    push(16'h0003, 16'hCFFF, 16'h0000, 1'b0);
    push(16'h0004, 16'h9409, 16'h0000, 1'b0);
    do_reset();
    for (int c = 0; c < 12; c++) begin
      i_ready = (c <= 2) || (c >= 7 && c <= 10);
      @(negedge i_clk);
      if (c >= 3 && c <= 6) begin
        check("stall_valid",   {15'b0, o_valid}, 16'h0001);
        check("stall_instr",   o_instr,   16'hFE00);
        check("stall_pm_addr", o_pm_addr, 16'h0003);
      end
      next_cycle();
    end
    check_drained("stall_drained");

    // Jump to 4 in cycle 2 while C003 is accepted.
    push(16'h0000, 16'hC003, 16'h0000, 1'b0);
    push(16'h0004, 16'h9409, 16'h0000, 1'b0);
    do_reset();
    for (int c = 0; c < 7; c++) begin
      i_ready      = (c <= 5);
      i_jump_valid = (c == 2);
      i_jump_addr  = 16'h0004;
      @(negedge i_clk);
      if (c == 3) check("jump_pm_addr", o_pm_addr, 16'h0004);
      if (c == 3 || c == 4) check("jump_valid_low", {15'b0, o_valid}, 16'h0000);
      if (c == 5) begin
        check("jump_valid", {15'b0, o_valid}, 16'h0001);
        check("jump_pc",    o_pc, 16'h0004);
      end
      next_cycle();
    end
    i_jump_valid = 1'b0;
    check_drained("jump_drained");

    // Two-word instruction waits for its second word and pops both.
    clear_mem();
    mem[0] = 16'h940C; mem[1] = 16'h1234; mem[2] = 16'h0000;
    push(16'h0000, 16'h940C, 16'h1234, 1'b1);
    push(16'h0002, 16'h0000, 16'h0000, 1'b0);
    do_reset();
    for (int c = 0; c < 7; c++) begin
      i_ready = (c <= 5);
      @(negedge i_clk);
      if (c == 2) begin
        check("tw_wait_valid", {15'b0, o_valid}, 16'h0000);
        check("tw_wait_instr", o_instr, 16'h0000);
        check("tw_wait_two",   {15'b0, o_two_word}, 16'h0000);
      end
      if (c == 3) check("tw_ext", o_instr_ext, 16'h1234);
      if (c == 5) check("tw_next_pc", o_pc, 16'h0002);
      next_cycle();
    end
    check_drained("tw_drained");

    // Fetch address wraps from FFFF to 0000.
    clear_mem();
    mem[16'hFFFF] = 16'h0000; mem[0] = 16'hC003;
    push(16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    push(16'h0000, 16'hC003, 16'h0000, 1'b0);
    do_reset();
    for (int c = 0; c < 6; c++) begin
      i_ready      = (c >= 1 && c <= 4);
      i_jump_valid = (c == 0);
      i_jump_addr  = 16'hFFFF;
      @(negedge i_clk);
      if (c == 1) check("wrap_pm_ffff", o_pm_addr, 16'hFFFF);
      if (c == 2) check("wrap_pm_0000", o_pm_addr, 16'h0000);
      if (c == 3) check("wrap_pc_ffff", o_pc, 16'hFFFF);
      if (c == 4) check("wrap_pc_0000", o_pc, 16'h0000);
      next_cycle();
    end
    i_jump_valid = 1'b0;
    check_drained("wrap_drained");

    // Reset while the buffer is full, then restart at RESET_PC.
    load_stream();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      i_ready = 1'b0;
      if (c >= 4) i_rst = 1'b1;
      @(negedge i_clk);
      if (c == 3) begin
        check("full_valid",   {15'b0, o_valid}, 16'h0001);
        check("full_pm_addr", o_pm_addr, 16'h0002);
      end
      if (c == 5) begin
        check("mid_rst_valid",   {15'b0, o_valid}, 16'h0000);
        check("mid_rst_pm_addr", o_pm_addr, 16'h0000);
      end
      next_cycle();
    end
    push(16'h0000, 16'hC003, 16'h0000, 1'b0);
    i_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      i_ready = (c == 2);
      @(negedge i_clk);
      if (c == 0) check("restart_pm_addr", o_pm_addr, 16'h0000);
      if (c == 1) check("restart_valid_low", {15'b0, o_valid}, 16'h0000);
      if (c == 2) check("restart_valid", {15'b0, o_valid}, 16'h0001);
      next_cycle();
    end
    check_drained("restart_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
